call_request_register: RTL and testbench

//  Builds and owns the per-floor request vector that door control consumes.
//  - Latches hall/car call-button presses into one sticky bit per floor.
//  - Watches door control's door/door_timer outputs and starts a dwell timer while the door is open.
//  - When the dwell expires, clears the served floor's bit so door control closes the door.
//  - Sits between the button inputs and door control, on the same clock.

---
 rtl/call_request_register.sv | 143 ++++++++++++++
 tb/tb_call_request_register.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/call_request_register.sv
//------------------------------------------------------------------------------
// Module  : call_request_register
// Brief   : Sticky per-floor call vector with door-open dwell timer that clears
//           the served floor's request once the door has dwelled long enough.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module call_request_register #(
   parameter int NUM_FLOORS   = 8,
   parameter int FLOOR_W      = 3,
   parameter int DWELL_CYCLES = 16,
   parameter int CNT_W        = $clog2(DWELL_CYCLES) + 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_FLOORS-1:0]             call_btn,
   input  logic [FLOOR_W-1:0]                current_floor,
   input  logic [1:0]                        door,
   input  logic                              door_timer,
   output logic [NUM_FLOORS-1:0]             requests,
   output logic                              served_pulse,
   output logic [FLOOR_W-1:0]                served_floor,
   output logic [$clog2(NUM_FLOORS+1)-1:0]   pending_count,
   output logic                              busy
);

   localparam int              c_PCW       = $clog2(NUM_FLOORS + 1);
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [1:0]      c_DOOR_OPEN = 2'b01;

   localparam logic [1:0]      c_IDLE      = 2'd0;
   localparam logic [1:0]      c_DWELL     = 2'd1;
   localparam logic [1:0]      c_HOLD      = 2'd2;

   logic [NUM_FLOORS-1:0] r_btn_q;
   logic [NUM_FLOORS-1:0] r_requests;
   logic [1:0]            r_state;
   logic [CNT_W-1:0]      r_dwell_cnt;
   logic [FLOOR_W-1:0]    r_floor;
   logic                  r_served_pulse;
   logic [FLOOR_W-1:0]    r_served_floor;

   logic [NUM_FLOORS-1:0] w_rise;
   logic [NUM_FLOORS-1:0] w_floor_onehot;
   logic                  w_floor_in_range;
   logic                  w_door_open;
   logic                  w_cond;
   logic [1:0]            w_state_nxt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic [FLOOR_W-1:0]    w_floor_nxt;
   logic [NUM_FLOORS-1:0] w_clr_mask;
   logic                  w_serve;
   logic [c_PCW-1:0]      w_pop;

   assign w_rise           = call_btn & ~r_btn_q;
   assign w_door_open      = (door == c_DOOR_OPEN);
   assign w_floor_in_range = (32'(current_floor) < NUM_FLOORS);
   // An out-of-range floor shifts the one-hot bit off the top, so it can never
   // select a request even without the explicit range term.
   assign w_floor_onehot   = NUM_FLOORS'(1) << current_floor;
   assign w_cond           = w_door_open && door_timer && w_floor_in_range &&
                             (|(r_requests & w_floor_onehot));

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_dwell_cnt;
      w_floor_nxt = r_floor;
      w_clr_mask  = '0;
      w_serve     = 1'b0;
      case (r_state)
         c_IDLE: begin
            if (w_cond) begin
               w_state_nxt = c_DWELL;
               w_cnt_nxt   = '0;
               w_floor_nxt = current_floor;
            end
         end
         c_DWELL: begin
            if (!w_cond || (current_floor != r_floor)) begin
               w_state_nxt = c_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_dwell_cnt == c_CNT_LAST) begin
               w_state_nxt = c_HOLD;
               w_clr_mask  = NUM_FLOORS'(1) << r_floor;
               w_serve     = 1'b1;
            end else begin
               w_cnt_nxt   = r_dwell_cnt + CNT_W'(1);
            end
         end
         c_HOLD: begin
            // Stay here until door control closes the door or the car moves,
            // so a re-press on the clearing edge gets a fresh dwell later.
            if (!w_door_open || (current_floor != r_floor)) begin
               w_state_nxt = c_IDLE;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = c_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_btn_q        <= '0;
         r_requests     <= '0;
         r_state        <= c_IDLE;
         r_dwell_cnt    <= '0;
         r_floor        <= '0;
         r_served_pulse <= 1'b0;
         r_served_floor <= '0;
      end else begin
         r_btn_q        <= call_btn;
         r_requests     <= (r_requests & ~w_clr_mask) | w_rise;
         r_state        <= w_state_nxt;
         r_dwell_cnt    <= w_cnt_nxt;
         r_floor        <= w_floor_nxt;
         r_served_pulse <= w_serve;
         if (w_serve) begin
            r_served_floor <= r_floor;
         end
      end
   end

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         w_pop = w_pop + c_PCW'(r_requests[i]);
      end
   end

   assign requests      = r_requests;
   assign served_pulse  = r_served_pulse;
   assign served_floor  = r_served_floor;
   assign pending_count = w_pop;
   assign busy          = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_call_request_register.sv
//------------------------------------------------------------------------------
// Module  : tb_call_request_register
// Brief   : Directed bench for call_request_register (8 floors, dwell of 4).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_call_request_register;

   localparam int c_NF = 8;
   localparam int c_FW = 3;
   localparam int c_DC = 4;

   logic            clk;
   logic            rst_n;
   logic [c_NF-1:0] call_btn;
   logic [c_FW-1:0] current_floor;
   logic [1:0]      door;
   logic            door_timer;
   logic [c_NF-1:0] requests;
   logic            served_pulse;
   logic [c_FW-1:0] served_floor;
   logic [3:0]      pending_count;
   logic            busy;

   int n_checks = 0;
   int n_pass   = 0;

   call_request_register #(
      .NUM_FLOORS  (c_NF),
      .FLOOR_W     (c_FW),
      .DWELL_CYCLES(c_DC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .call_btn     (call_btn),
      .current_floor(current_floor),
      .door         (door),
      .door_timer   (door_timer),
      .requests     (requests),
      .served_pulse (served_pulse),
      .served_floor (served_floor),
      .pending_count(pending_count),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic press(input logic [c_NF-1:0] mask);
      call_btn = mask;
      tick();
      call_btn = '0;
   endtask

   task automatic door_open_at(input logic [c_FW-1:0] f);
      current_floor = f;
      door          = 2'b01;
      door_timer    = 1'b1;
   endtask

   task automatic door_close();
      door       = 2'b00;
      door_timer = 1'b0;
   endtask

   initial begin
      rst_n         = 1'b0;
      call_btn      = '0;
      current_floor = '0;
      door          = 2'b00;
      door_timer    = 1'b0;

      // 1: reset state
      tick();
      tick();
      chk("rst_requests", requests, 8'h00);
      chk("rst_pulse", served_pulse, 0);
      chk("rst_pending", pending_count, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;

      // 2: single-cycle press then a held press
      press(8'h08);
      chk("press3_requests", requests, 8'h08);
      call_btn = 8'h20;
      tick();
      chk("press5_requests", requests, 8'h28);
      for (int i = 0; i < 9; i++) tick();
      chk("held5_requests", requests, 8'h28);
      chk("held5_pending", pending_count, 2);
      call_btn = '0;
      tick();

      // 3: full dwell at floor 3
      do_reset();
      press(8'h08);
      door_open_at(3'd3);
      tick();
      chk("dw_e1_busy", busy, 1);
      tick(); tick(); tick();
      chk("dw_e4_pulse", served_pulse, 0);
      chk("dw_e4_requests", requests, 8'h08);
      tick();
      chk("dw_e5_requests", requests, 8'h00);
      chk("dw_e5_pulse", served_pulse, 1);
      chk("dw_e5_floor", served_floor, 3);
      tick();
      chk("dw_e6_pulse", served_pulse, 0);
      chk("dw_e6_hold_busy", busy, 1);
      chk("dw_e6_floor_held", served_floor, 3);
      door_close();
      tick();
      chk("dw_close_busy", busy, 0);

      // 4: door drops mid-dwell
      do_reset();
      press(8'h08);
      door_open_at(3'd3);
      tick(); tick();
      door_close();
      tick();
      chk("ab_busy", busy, 0);
      chk("ab_pulse", served_pulse, 0);
      tick(); tick(); tick();
      chk("ab_requests", requests, 8'h08);
      chk("ab_pulse_late", served_pulse, 0);

      // 5: re-press on the clearing edge keeps the bit, second dwell clears it
      do_reset();
      press(8'h08);
      door_open_at(3'd3);
      tick(); tick(); tick(); tick();
      call_btn = 8'h08;
      tick();
      call_btn = '0;
      chk("rp_e5_pulse", served_pulse, 1);
      chk("rp_e5_requests", requests, 8'h08);
      tick(); tick();
      chk("rp_hold_no_restart", served_pulse, 0);
      chk("rp_hold_busy", busy, 1);
      door_close();
      tick();
      chk("rp_idle", busy, 0);
      door_open_at(3'd3);
      tick(); tick(); tick(); tick();
      chk("rp2_e4_requests", requests, 8'h08);
      tick();
      chk("rp2_e5_requests", requests, 8'h00);
      chk("rp2_e5_pulse", served_pulse, 1);
      door_close();
      tick();

      // car moves to another floor mid-dwell: restart there
      do_reset();
      press(8'h0C);
      door_open_at(3'd3);
      tick(); tick();
      current_floor = 3'd2;
      tick();
      chk("mv_e3_busy", busy, 0);
      tick();
      chk("mv_e4_busy", busy, 1);
      tick(); tick(); tick();
      chk("mv_e7_requests", requests, 8'h0C);
      tick();
      chk("mv_e8_requests", requests, 8'h08);
      chk("mv_e8_floor", served_floor, 2);
      door_close();
      tick();

      // 6: reset during dwell, button held through reset
      do_reset();
      press(8'h88);
      chk("rd_requests", requests, 8'h88);
      chk("rd_pending", pending_count, 2);
      door_open_at(3'd3);
      tick(); tick();
      rst_n    = 1'b0;
      call_btn = 8'h02;
      tick();
      chk("rd_requests_clr", requests, 8'h00);
      chk("rd_busy", busy, 0);
      chk("rd_pulse", served_pulse, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rd_held_press", requests, 8'h02);
      tick(); tick(); tick(); tick(); tick();
      chk("rd_held_once", requests, 8'h02);
      chk("rd_no_pulse", served_pulse, 0);
      chk("rd_idle", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
